// File: rtl/hamming_pkg.sv
// Shared sizing helpers for the streaming Hamming encoder.
// Defining HAMMING_SECDED_EN adds an overall-parity MSB to every segment codeword.
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
  localparam bit SecdedEn = 1'b1;
`else
  localparam bit SecdedEn = 1'b0;
`endif

  // Smallest r with 2^r >= seg_w + r + 1.
  function automatic int unsigned hamming_r(input int unsigned seg_w);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < seg_w + r + 1) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned hamming_cw_w(input int unsigned seg_w, input bit secded);
    return seg_w + hamming_r(seg_w) + (secded ? 32'd1 : 32'd0);
  endfunction

  function automatic bit is_pow2(input int unsigned p);
    return (p != 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data positions (1-based p, stored at bit p-1) covered by the parity bit at 2^j.
  function automatic logic [63:0] parity_mask(input int unsigned j, input int unsigned w);
    logic [63:0] m;
    m = '0;
    for (int unsigned p = 1; p <= w; p++) begin
      if (!is_pow2(p) && (((p >> j) & 32'd1) != 0)) m = m | (64'd1 << (p - 1));
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_seg_enc.sv
// Combinational Hamming encoder for one SEG_W-bit segment.
// With HAMMING_SECDED_EN the codeword gains an overall even-parity MSB.
module hamming_seg_enc
  import hamming_pkg::*;
#(
  parameter int unsigned SEG_W = 4,
  localparam int unsigned CW_W = hamming_cw_w(SEG_W, SecdedEn)
) (
  input  logic [SEG_W-1:0] data_i,
  output logic [CW_W-1:0]  code_o
);

  localparam int unsigned HamW = SEG_W + hamming_r(SEG_W);

  logic [HamW-1:0] dpos;
  logic [HamW-1:0] ham;

  for (genvar p = 1; p <= HamW; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      localparam logic [63:0] Mask = parity_mask($clog2(p), HamW);
      assign dpos[p-1] = 1'b0;
      assign ham[p-1]  = ^(dpos & Mask[HamW-1:0]);
    end else begin : g_dat
      // Non-power-of-2 position p carries data bit p-1-ceil(log2(p)).
      assign dpos[p-1] = data_i[p-1-$clog2(p)];
      assign ham[p-1]  = dpos[p-1];
    end
  end

`ifdef HAMMING_SECDED_EN
  assign code_o = {^ham, ham};
`else
  assign code_o = ham;
`endif

endmodule

// File: rtl/hamming_stream_enc.sv
// Two-stage valid/ready Hamming encoder: S1 holds the raw word, S2 the encoded word.
// HAMMING_SECDED_EN selects the SECDED codeword format (see hamming_pkg).
module hamming_stream_enc
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEG_W  = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned CW_W  = hamming_cw_w(SEG_W, SecdedEn),
  localparam int unsigned OUT_W = (DATA_W / SEG_W) * CW_W
) (
  input  logic              i_SCLK,
  input  logic              i_RESET,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              i_VALID,
  output logic              o_READY,
  output logic [OUT_W-1:0]  o_DATA,
  output logic              o_VALID,
  input  logic              i_READY,
  input  logic              i_CNT_CLR,
  output logic [CNT_W-1:0]  o_WORD_CNT
);

  localparam int unsigned NumSeg = DATA_W / SEG_W;

  if ((DATA_W % SEG_W) != 0) begin : g_bad_data_w
    $error("DATA_W must be an integer multiple of SEG_W");
  end
  if (SEG_W < 2 || SEG_W > 57) begin : g_bad_seg_w
    $error("SEG_W must lie in 2..57");
  end

  logic              s1_v_q, s1_v_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s2_v_q, s2_v_d;
  logic [OUT_W-1:0]  s2_data_q, s2_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  enc;
  logic              s1_load, s2_load, in_hs, out_hs;

  for (genvar k = 0; k < NumSeg; k++) begin : g_seg
    hamming_seg_enc #(
      .SEG_W (SEG_W)
    ) u_seg_enc (
      .data_i (s1_data_q[k*SEG_W +: SEG_W]),
      .code_o (enc[k*CW_W +: CW_W])
    );
  end

  // Ready ripples back combinationally from i_READY so a full pipe never bubbles.
  assign s2_load = ~s2_v_q | i_READY;
  assign s1_load = ~s1_v_q | s2_load;
  assign in_hs   = i_VALID & s1_load;
  assign out_hs  = s2_v_q & i_READY;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    cnt_d     = cnt_q;
    if (s1_load) begin
      s1_v_d = i_VALID;
      if (in_hs) s1_data_d = i_DATA;
    end
    if (s2_load) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) s2_data_d = enc;
    end
    if (i_CNT_CLR) begin
      cnt_d = '0;
    end else if (out_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_SCLK) begin
    if (i_RESET) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_READY    = s1_load;
  assign o_DATA     = s2_data_q;
  assign o_VALID    = s2_v_q;
  assign o_WORD_CNT = cnt_q;

endmodule

// File: tb/tb_hamming_stream_enc.sv
// Directed bench: default 16/4 encoder plus a 24/8 instance with a 4-bit counter,
// whose outputs are checked by syndrome decoding rather than by re-encoding.
module tb_hamming_stream_enc;

`ifdef HAMMING_SECDED_EN
  localparam int CW_A = 8;
  localparam int CW_B = 13;
  localparam logic [63:0] E1  = 64'h87;
  localparam logic [63:0] E2  = 64'h99;
  localparam logic [63:0] E3  = 64'h1E;
  localparam logic [63:0] EBB = 64'h55555555;
`else
  localparam int CW_A = 7;
  localparam int CW_B = 12;
  localparam logic [63:0] E1  = 64'h7;
  localparam logic [63:0] E2  = 64'h19;
  localparam logic [63:0] E3  = 64'h1E;
  localparam logic [63:0] EBB = 64'hAB56AD5;
`endif
  localparam int OUT_A = 4 * CW_A;
  localparam int OUT_B = 3 * CW_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, v_a, rdy_a, clr_a, ordy_a, ov_a;
  logic [15:0]      d_a;
  logic [OUT_A-1:0] od_a;
  logic [15:0]      cnt_a;
  logic             rst_b, v_b, rdy_b, clr_b, ordy_b, ov_b;
  logic [23:0]      d_b;
  logic [OUT_B-1:0] od_b;
  logic [3:0]       cnt_b;

  hamming_stream_enc u_dut_a (
    .i_SCLK (clk), .i_RESET (rst_a), .i_DATA (d_a), .i_VALID (v_a), .o_READY (ordy_a),
    .o_DATA (od_a), .o_VALID (ov_a), .i_READY (rdy_a), .i_CNT_CLR (clr_a), .o_WORD_CNT (cnt_a)
  );

  hamming_stream_enc #(.DATA_W (24), .SEG_W (8), .CNT_W (4)) u_dut_b (
    .i_SCLK (clk), .i_RESET (rst_b), .i_DATA (d_b), .i_VALID (v_b), .o_READY (ordy_b),
    .o_DATA (od_b), .o_VALID (ov_b), .i_READY (rdy_b), .i_CNT_CLR (clr_b), .o_WORD_CNT (cnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int syndrome(input logic [63:0] seg);
    int s;
    s = 0;
    for (int p = 1; p <= 12; p++) if (((seg >> (p - 1)) & 64'd1) != 0) s = s ^ p;
    return s;
  endfunction

  function automatic logic [7:0] extract(input logic [63:0] seg);
    logic [7:0] r;
    int idx;
    r = '0;
    idx = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        r = r | (8'(((seg >> (p - 1)) & 64'd1)) << idx);
        idx++;
      end
    end
    return r;
  endfunction

  task automatic check_wide(input logic [OUT_B-1:0] cw_all, input logic [23:0] data,
                            input int idx);
    logic [63:0] all, seg, flip;
    all = 64'(cw_all);
    for (int k = 0; k < 3; k++) begin
      seg = (all >> (k * CW_B)) & ((64'd1 << CW_B) - 64'd1);
      chk($sformatf("w%0d_s%0d_syn0", idx, k), 64'(syndrome(seg)), 64'd0);
      chk($sformatf("w%0d_s%0d_data", idx, k), 64'(extract(seg)), 64'(data[k*8 +: 8]));
`ifdef HAMMING_SECDED_EN
      chk($sformatf("w%0d_s%0d_ovpar", idx, k), 64'(^seg), 64'd0);
`endif
      for (int b = 0; b < 12; b++) begin
        flip = seg ^ (64'd1 << b);
        chk($sformatf("w%0d_s%0d_flip%0d", idx, k, b), 64'(syndrome(flip)), 64'(b + 1));
      end
    end
  endtask

  logic [23:0] words [17];
  int sent, got;

  initial begin
    rst_a = 1; v_a = 0; rdy_a = 0; clr_a = 0; d_a = '0;
    rst_b = 1; v_b = 0; rdy_b = 0; clr_b = 0; d_b = '0;
    cyc(); cyc();
    rst_a = 0; rst_b = 0;
    #1;
    chk("rst_ovalid", 64'(ov_a), 0);
    chk("rst_odata", 64'(od_a), 0);
    chk("rst_cnt", 64'(cnt_a), 0);
    chk("rst_oready", 64'(ordy_a), 1);

    // Single word, latency 2.
    d_a = 16'h0001; v_a = 1; rdy_a = 1;
    cyc();
    v_a = 0;
    chk("lat_one_cycle", 64'(ov_a), 0);
    cyc();
    chk("enc1_valid", 64'(ov_a), 1);
    chk("enc1_data", 64'(od_a), E1);
    cyc();
    chk("enc1_cnt", 64'(cnt_a), 1);
    chk("enc1_drained", 64'(ov_a), 0);

    // All four segments in parallel.
    d_a = 16'hBBBB; v_a = 1;
    cyc();
    v_a = 0;
    cyc();
    chk("encbb_data", 64'(od_a), EBB);
    cyc();
    chk("encbb_cnt", 64'(cnt_a), 2);

    clr_a = 1;
    cyc();
    clr_a = 0;
    chk("clr_cnt", 64'(cnt_a), 0);

    // Back-pressure: two words fill the pipe, third waits.
    rdy_a = 0; v_a = 1; d_a = 16'h0001;
    #1;
    chk("bp_ready0", 64'(ordy_a), 1);
    cyc();
    d_a = 16'h0002;
    cyc();
    d_a = 16'h0003;
    #1;
    chk("bp_full_noready", 64'(ordy_a), 0);
    cyc();
    chk("bp_hold_valid", 64'(ov_a), 1);
    chk("bp_hold_data", 64'(od_a), E1);
    cyc();
    chk("bp_hold_data2", 64'(od_a), E1);
    rdy_a = 1;
    #1;
    chk("bp_ready_comb", 64'(ordy_a), 1);
    cyc();
    v_a = 0;
    chk("bp_word2", 64'(od_a), E2);
    cyc();
    chk("bp_word3", 64'(od_a), E3);
    chk("bp_word3_valid", 64'(ov_a), 1);
    cyc();
    chk("bp_empty", 64'(ov_a), 0);
    chk("bp_cnt", 64'(cnt_a), 3);

    // Reset with both stages full.
    rdy_a = 0; v_a = 1; d_a = 16'h0005;
    cyc();
    d_a = 16'h0006;
    cyc();
    chk("mid_full", 64'(ordy_a), 0);
    rst_a = 1; v_a = 0;
    cyc();
    rst_a = 0;
    #1;
    chk("mid_ovalid", 64'(ov_a), 0);
    chk("mid_odata", 64'(od_a), 0);
    chk("mid_cnt", 64'(cnt_a), 0);
    chk("mid_oready", 64'(ordy_a), 1);
    rdy_a = 1;
    cyc(); cyc();
    chk("mid_discarded", 64'(ov_a), 0);

    // Wide instance: 17 random words under random back-pressure, 4-bit counter wraps.
    for (int i = 0; i < 17; i++) words[i] = 24'($urandom);
    sent = 0;
    got = 0;
    for (int c = 0; c < 300 && got < 17; c++) begin
      v_b = (sent < 17);
      d_b = (sent < 17) ? words[sent] : 24'h0;
      rdy_b = ($urandom_range(0, 3) != 0);
      #1;
      if (ov_b && rdy_b) begin
        check_wide(od_b, words[got], got);
        got++;
      end
      if (v_b && ordy_b) sent++;
      cyc();
    end
    v_b = 0;
    chk("wide_words_out", 64'(got), 17);
    chk("wide_cnt_wrap", 64'(cnt_b), 1);

    // Clear wins over a same-cycle output handshake.
    v_b = 1; d_b = 24'h123456; rdy_b = 1;
    cyc();
    v_b = 0;
    cyc();
    chk("clrhs_pre_valid", 64'(ov_b), 1);
    clr_b = 1;
    cyc();
    clr_b = 0;
    chk("clrhs_cnt", 64'(cnt_b), 0);
    chk("clrhs_drained", 64'(ov_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
